zeta_addr_ctrl: RTL and testbench

Address sequencer for the per-stage zeta ROMs of the pipelined two-lane NTT. It tracks each butterfly-pair beat as it flows through the stage pipeline. For every stage it issues the zeta address that lane 0 and lane 1 need, with a per-stage valid. It also flags frame completion and frame-sync errors. It sits between the NTT input handshake and the zeta ROM bank. It owns the ROM's address inputs.

---
 rtl/zeta_addr_ctrl.sv | 151 +++++++++++++++
 tb/tb_zeta_addr_ctrl.sv | 378 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/zeta_addr_ctrl.sv
// zeta_addr_ctrl
// Zeta ROM address sequencer for the pipelined two-lane NTT. It follows every butterfly-pair
// beat through the stage pipeline. For each stage it issues the lane 0 / lane 1 zeta address
// together with a per-stage valid. It also flags frame completion and frame-sync errors.
//
// Ports
//   clk           rising-edge clock
//   rst_n         asynchronous active-low reset
//   in_valid_i    a butterfly pair (two butterflies) is sampled into stage 0 this cycle
//   in_first_i    qualifies in_valid_i; marks beat 0 of a frame
//   stage_valid_o stage s holds a beat whose zeta address is presented this cycle
//   rom_addr_o    rom_addr_o[l][k] = lane-l zeta address for stage k+1 (stage 0 has a fixed zeta)
//   frame_done_o  one-cycle pulse with the last beat of a frame at the final stage
//   busy_o        beats in flight or any stage counter nonzero
//   sync_err_o    sticky: in_first_i arrived while the stage-0 counter was not 0
//
// A beat sampled at edge E is processed by stage s at edge E + s*STAGE_LAT + 1. The outputs are
// registered at that edge. The ROM read is synchronous, so zeta data lags stage_valid_o by one
// cycle.

module zeta_addr_ctrl #(
    parameter int unsigned NTT_STAGE_CNT = 8,
    parameter int unsigned STAGE_LAT     = 3
) (
    input  logic                                                 clk,
    input  logic                                                 rst_n,
    input  logic                                                 in_valid_i,
    input  logic                                                 in_first_i,
    output logic [NTT_STAGE_CNT-1:0]                             stage_valid_o,
    output logic [1:0][NTT_STAGE_CNT-2:0][NTT_STAGE_CNT-2:0]     rom_addr_o,
    output logic                                                 frame_done_o,
    output logic                                                 busy_o,
    output logic                                                 sync_err_o
);

    // Counter width covers N/4 beats; address width covers N/2 butterflies.
    localparam int unsigned CW    = NTT_STAGE_CNT - 2;
    localparam int unsigned AW    = NTT_STAGE_CNT - 1;
    // Bit s*STAGE_LAT feeds stage s. The extra tap gives stage 0 its one-edge latency.
    localparam int unsigned SrLen = (NTT_STAGE_CNT - 1) * STAGE_LAT + 1;

    logic [SrLen-1:0]         vld_sr_q;
    logic [SrLen-1:0]         fst_sr_q;
    logic [NTT_STAGE_CNT-1:0] st_v;
    logic [NTT_STAGE_CNT-1:0] st_f;
    logic [NTT_STAGE_CNT-1:0] cnt_nz;
    logic                     last_beat;
    logic                     frame_done_q;
    logic                     sync_err_q;
    logic                     sync_err_d;

    // ------------------------------------------------------------------------------------------
    // Beat pipeline: valid and first tag travel together.
    // in_first_i without in_valid_i is dropped here.
    // ------------------------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_sr_q <= '0;
            fst_sr_q <= '0;
        end else begin
            vld_sr_q <= {vld_sr_q[SrLen-2:0], in_valid_i};
            fst_sr_q <= {fst_sr_q[SrLen-2:0], in_valid_i & in_first_i};
        end
    end

    // ------------------------------------------------------------------------------------------
    // Per-stage beat counter, valid register and lane addresses
    // ------------------------------------------------------------------------------------------
    for (genvar s = 0; s < NTT_STAGE_CNT; s++) begin : g_stage
        logic [CW-1:0] cnt_q;
        logic [CW-1:0] cnt_d;
        logic [CW-1:0] idx;
        logic          sv_q;

        assign st_v[s] = vld_sr_q[s*STAGE_LAT];
        assign st_f[s] = fst_sr_q[s*STAGE_LAT];

        // A first tag realigns this stage to beat 0, whatever the counter holds.
        assign idx = st_f[s] ? '0 : cnt_q;

        // Natural wrap at N/4 because the counter is exactly CW bits wide.
        always_comb begin
            cnt_d = cnt_q;
            if (st_v[s]) begin
                cnt_d = idx + CW'(1);
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt_q <= '0;
                sv_q  <= 1'b0;
            end else begin
                cnt_q <= cnt_d;
                sv_q  <= st_v[s];
            end
        end

        assign stage_valid_o[s] = sv_q;
        assign cnt_nz[s]        = |cnt_q;

        if (s > 0) begin : g_addr
            for (genvar l = 0; l < 2; l++) begin : g_lane
                logic [AW-1:0] bfly;
                logic [AW-1:0] addr_q;

                // Butterfly index b = 2*c + l. Stage s keeps its top s bits, zero-extended.
                assign bfly = {idx, 1'(l)};

                // The address holds while the stage is idle.
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        addr_q <= '0;
                    end else if (st_v[s]) begin
                        addr_q <= bfly >> (AW - s);
                    end
                end

                assign rom_addr_o[l][s-1] = addr_q;
            end
        end

        if (s == NTT_STAGE_CNT - 1) begin : g_last
            assign last_beat = st_v[s] & (&idx);
        end
    end

    // ------------------------------------------------------------------------------------------
    // Frame status
    // ------------------------------------------------------------------------------------------
    // The stage-0 counter is checked where the tag is consumed. That is one edge after sampling,
    // so every earlier beat has already been counted.
    assign sync_err_d = sync_err_q | (st_v[0] & st_f[0] & cnt_nz[0]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_done_q <= 1'b0;
            sync_err_q   <= 1'b0;
        end else begin
            frame_done_q <= last_beat;
            sync_err_q   <= sync_err_d;
        end
    end

    assign frame_done_o = frame_done_q;
    assign sync_err_o   = sync_err_q;

    // Registered terms only. busy_o drops one cycle after the last beat leaves the final stage.
    assign busy_o = (|vld_sr_q) | (|stage_valid_o) | (|cnt_nz);

endmodule

// File: tb/tb_zeta_addr_ctrl.sv
module tb_zeta_addr_ctrl;

    localparam int MAXC = 400;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b1;
    logic                  in_valid = 1'b0;
    logic                  in_first = 1'b0;
    logic [7:0]            stage_valid;
    logic [1:0][6:0][6:0]  rom_addr;
    logic                  frame_done;
    logic                  busy;
    logic                  sync_err;

    int tests = 0;
    int fails = 0;

    // Stimulus per sampling edge, with the frame beat number the bench assigns to each beat.
    bit in_v [MAXC];
    bit in_f [MAXC];
    int bidx [MAXC];

    // Outputs observed shortly after edge k.
    logic [7:0]           o_sv   [MAXC];
    logic [1:0][6:0][6:0] o_ra   [MAXC];
    logic                 o_fd   [MAXC];
    logic                 o_busy [MAXC];
    logic                 o_se   [MAXC];

    zeta_addr_ctrl #(
        .NTT_STAGE_CNT (8),
        .STAGE_LAT     (3)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid_i    (in_valid),
        .in_first_i    (in_first),
        .stage_valid_o (stage_valid),
        .rom_addr_o    (rom_addr),
        .frame_done_o  (frame_done),
        .busy_o        (busy),
        .sync_err_o    (sync_err)
    );

    always #5 clk = ~clk;

    task automatic clear_stim();
        for (int k = 0; k < MAXC; k++) begin
            in_v[k] = 1'b0;
            in_f[k] = 1'b0;
            bidx[k] = 0;
        end
    endtask

    // Drives edges 0..n-1 from the stimulus arrays and records the outputs 2 time units
    // after each edge.
    task automatic drive_stream(input int n);
        for (int k = 0; k < n; k++) begin
            in_valid = in_v[k];
            in_first = in_f[k];
            @(posedge clk);
            #2;
            o_sv[k]   = stage_valid;
            o_ra[k]   = rom_addr;
            o_fd[k]   = frame_done;
            o_busy[k] = busy;
            o_se[k]   = sync_err;
        end
        in_valid = 1'b0;
        in_first = 1'b0;
    endtask

    // A beat sampled at edge e is visible at stage s after edge e + 3s + 1.
    function automatic logic [7:0] exp_sv(input int k);
        logic [7:0] r;
        r = '0;
        for (int s = 0; s < 8; s++) begin
            int e;
            e = k - (3 * s + 1);
            if (e >= 0) r[s] = in_v[e];
        end
        return r;
    endfunction

    function automatic logic [6:0] exp_addr(input int k, input int s, input int l);
        int e;
        int v;
        e = k - (3 * s + 1);
        v = (2 * bidx[e] + l) >> (7 - s);
        return v[6:0];
    endfunction

    function automatic logic exp_fd(input int k);
        int e;
        e = k - 22;
        return (e >= 0) && in_v[e] && (bidx[e] == 63);
    endfunction

    task automatic apply_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        #1;
        apply_reset();
        clear_stim();
        drive_stream(10);
        for (int k = 0; k < 10; k++) begin
            tests++;
            if ({o_sv[k], o_fd[k], o_busy[k], o_se[k]} !== 11'd0) begin
                fails++;
                $display("FAIL reset_idle k=%0d got sv=%b fd=%b busy=%b se=%b exp all 0",
                         k, o_sv[k], o_fd[k], o_busy[k], o_se[k]);
            end
            tests++;
            if (o_ra[k] !== '0) begin
                fails++;
                $display("FAIL reset_addr k=%0d got %h exp 0", k, o_ra[k]);
            end
        end
    endtask

    task automatic test_single_frame();
        int nfd;
        clear_stim();
        for (int k = 0; k < 64; k++) begin
            in_v[k] = 1'b1;
            bidx[k] = k;
        end
        in_f[0] = 1'b1;
        drive_stream(100);
        nfd = 0;
        for (int k = 0; k < 100; k++) begin
            logic [7:0] ev;
            ev = exp_sv(k);
            tests++;
            if (o_sv[k] !== ev) begin
                fails++;
                $display("FAIL single_sv k=%0d got %b exp %b", k, o_sv[k], ev);
            end
            for (int s = 1; s < 8; s++) begin
                if (ev[s]) begin
                    for (int l = 0; l < 2; l++) begin
                        tests++;
                        if (o_ra[k][l][s-1] !== exp_addr(k, s, l)) begin
                            fails++;
                            $display("FAIL single_addr k=%0d s=%0d l=%0d got %0d exp %0d",
                                     k, s, l, o_ra[k][l][s-1], exp_addr(k, s, l));
                        end
                    end
                end
            end
            tests++;
            if (o_fd[k] !== exp_fd(k)) begin
                fails++;
                $display("FAIL single_fd k=%0d got %b exp %b", k, o_fd[k], exp_fd(k));
            end
            tests++;
            if (o_busy[k] !== (k <= 85)) begin
                fails++;
                $display("FAIL single_busy k=%0d got %b exp %b", k, o_busy[k], k <= 85);
            end
            if (o_fd[k] === 1'b1) nfd++;
        end
        // Hand-computed landmarks.
        tests++;
        if ({o_ra[4][1][0], o_ra[4][0][0], o_ra[35][1][0], o_ra[35][0][0]} !== 28'd0) begin
            fails++;
            $display("FAIL single_s1_low got %0d/%0d %0d/%0d exp 0/0 0/0",
                     o_ra[4][0][0], o_ra[4][1][0], o_ra[35][0][0], o_ra[35][1][0]);
        end
        tests++;
        if (o_ra[36][0][0] !== 7'd1 || o_ra[36][1][0] !== 7'd1) begin
            fails++;
            $display("FAIL single_s1_high got %0d/%0d exp 1/1", o_ra[36][0][0], o_ra[36][1][0]);
        end
        tests++;
        if (o_ra[85][0][6] !== 7'd126 || o_ra[85][1][6] !== 7'd127 || o_fd[85] !== 1'b1) begin
            fails++;
            $display("FAIL single_last got %0d/%0d fd=%b exp 126/127 fd=1",
                     o_ra[85][0][6], o_ra[85][1][6], o_fd[85]);
        end
        tests++;
        if (nfd != 1) begin
            fails++;
            $display("FAIL single_fd_count got %0d exp 1", nfd);
        end
    endtask

    task automatic test_gaps();
        int nfd;
        clear_stim();
        for (int j = 0; j < 64; j++) begin
            in_v[2*j] = 1'b1;
            bidx[2*j] = j;
        end
        in_f[0] = 1'b1;
        drive_stream(160);
        nfd = 0;
        for (int k = 0; k < 160; k++) begin
            logic [7:0] ev;
            ev = exp_sv(k);
            tests++;
            if (o_sv[k] !== ev) begin
                fails++;
                $display("FAIL gaps_sv k=%0d got %b exp %b", k, o_sv[k], ev);
            end
            for (int s = 1; s < 8; s++) begin
                if (ev[s]) begin
                    for (int l = 0; l < 2; l++) begin
                        tests++;
                        if (o_ra[k][l][s-1] !== exp_addr(k, s, l)) begin
                            fails++;
                            $display("FAIL gaps_addr k=%0d s=%0d l=%0d got %0d exp %0d",
                                     k, s, l, o_ra[k][l][s-1], exp_addr(k, s, l));
                        end
                    end
                end
            end
            tests++;
            if (o_fd[k] !== exp_fd(k) || o_busy[k] !== (k <= 148)) begin
                fails++;
                $display("FAIL gaps_fd_busy k=%0d got fd=%b busy=%b exp fd=%b busy=%b",
                         k, o_fd[k], o_busy[k], exp_fd(k), k <= 148);
            end
            if (o_fd[k] === 1'b1) nfd++;
        end
        tests++;
        if (nfd != 1 || o_fd[148] !== 1'b1) begin
            fails++;
            $display("FAIL gaps_fd_once got count=%0d fd148=%b exp 1 and 1", nfd, o_fd[148]);
        end
    endtask

    task automatic test_back_to_back();
        int nfd;
        clear_stim();
        for (int k = 0; k < 128; k++) begin
            in_v[k] = 1'b1;
            bidx[k] = k % 64;
        end
        in_f[0]  = 1'b1;
        in_f[64] = 1'b1;
        drive_stream(170);
        nfd = 0;
        for (int k = 0; k < 170; k++) begin
            logic [7:0] ev;
            ev = exp_sv(k);
            tests++;
            if (o_sv[k] !== ev) begin
                fails++;
                $display("FAIL b2b_sv k=%0d got %b exp %b", k, o_sv[k], ev);
            end
            if (ev[7]) begin
                for (int l = 0; l < 2; l++) begin
                    tests++;
                    if (o_ra[k][l][6] !== exp_addr(k, 7, l)) begin
                        fails++;
                        $display("FAIL b2b_s7 k=%0d l=%0d got %0d exp %0d",
                                 k, l, o_ra[k][l][6], exp_addr(k, 7, l));
                    end
                end
            end
            tests++;
            if (o_fd[k] !== exp_fd(k) || o_busy[k] !== (k <= 149)) begin
                fails++;
                $display("FAIL b2b_fd_busy k=%0d got fd=%b busy=%b exp fd=%b busy=%b",
                         k, o_fd[k], o_busy[k], exp_fd(k), k <= 149);
            end
            if (o_fd[k] === 1'b1) nfd++;
        end
        tests++;
        if (nfd != 2 || o_fd[85] !== 1'b1 || o_fd[149] !== 1'b1) begin
            fails++;
            $display("FAIL b2b_fd_pair got count=%0d fd85=%b fd149=%b exp 2 1 1",
                     nfd, o_fd[85], o_fd[149]);
        end
    endtask

    task automatic test_sync_err();
        int nfd;
        clear_stim();
        for (int k = 0; k < 64; k++) begin
            in_v[k] = 1'b1;
            bidx[k] = (k < 10) ? k : k - 10;
        end
        in_f[0]  = 1'b1;
        in_f[10] = 1'b1;
        drive_stream(100);
        nfd = 0;
        for (int k = 0; k < 100; k++) begin
            if (k < 10 || k >= 11) begin
                tests++;
                if (o_se[k] !== (k >= 11)) begin
                    fails++;
                    $display("FAIL sync_err k=%0d got %b exp %b", k, o_se[k], k >= 11);
                end
            end
            if (k >= 10 && k < 74) begin
                for (int l = 0; l < 2; l++) begin
                    tests++;
                    if (o_ra[k][l][2] !== exp_addr(k, 3, l)) begin
                        fails++;
                        $display("FAIL sync_s3 k=%0d l=%0d got %0d exp %0d",
                                 k, l, o_ra[k][l][2], exp_addr(k, 3, l));
                    end
                end
            end
            if (o_fd[k] === 1'b1) nfd++;
        end
        tests++;
        if (o_ra[19][0][2] !== 7'd1 || o_ra[19][1][2] !== 7'd1 ||
            o_ra[20][0][2] !== 7'd0 || o_ra[20][1][2] !== 7'd0) begin
            fails++;
            $display("FAIL sync_s3_restart got %0d/%0d then %0d/%0d exp 1/1 then 0/0",
                     o_ra[19][0][2], o_ra[19][1][2], o_ra[20][0][2], o_ra[20][1][2]);
        end
        tests++;
        if (nfd != 0) begin
            fails++;
            $display("FAIL sync_no_fd got %0d exp 0", nfd);
        end
    endtask

    task automatic test_mid_reset();
        clear_stim();
        apply_reset();
        for (int k = 0; k < 30; k++) begin
            in_v[k] = 1'b1;
            bidx[k] = k;
        end
        in_f[0] = 1'b1;
        drive_stream(30);
        tests++;
        if (busy !== 1'b1 || stage_valid === 8'd0) begin
            fails++;
            $display("FAIL midrst_pre got busy=%b sv=%b exp busy=1 sv!=0", busy, stage_valid);
        end
        rst_n = 1'b0;
        #1;
        tests++;
        if ({stage_valid, frame_done, busy, sync_err} !== 11'd0 || rom_addr !== '0) begin
            fails++;
            $display("FAIL midrst_now got sv=%b fd=%b busy=%b se=%b addr=%h exp all 0",
                     stage_valid, frame_done, busy, sync_err, rom_addr);
        end
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        clear_stim();
        drive_stream(30);
        for (int k = 0; k < 30; k++) begin
            tests++;
            if ({o_sv[k], o_fd[k], o_busy[k]} !== 10'd0) begin
                fails++;
                $display("FAIL midrst_after k=%0d got sv=%b fd=%b busy=%b exp all 0",
                         k, o_sv[k], o_fd[k], o_busy[k]);
            end
        end
        test_single_frame();
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_gaps();
        test_back_to_back();
        test_sync_err();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
